// File: rtl/nanov_store_periph.sv
// Store-side peripheral for nanoV_cpu: captures store address/data from the CPU's serial
// data bus and performs memory-mapped writes to a GPIO register and a FIFO-fed UART TX.
module nanov_store_periph #(
    parameter logic [7:0] PERIPH_PAGE  = 8'h10,
    parameter logic [7:0] GPIO_OFFSET  = 8'h00,
    parameter logic [7:0] UART_OFFSET  = 8'h04,
    parameter int         GPIO_WIDTH   = 8,
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           cpu_data,
    input  logic                  cpu_store_addr,
    input  logic                  cpu_store_data,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  uart_tx,
    output logic                  uart_busy,
    output logic                  uart_overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int DIV_W = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [31:0]           addr_q, addr_d;
    logic                  addr_pending_q, addr_pending_d;
    logic [GPIO_WIDTH-1:0] gpio_q, gpio_d;
    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [7:0]            mem_d [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic [1:0]            state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic [31:0] wdata;
    logic        do_write, page_hit, gpio_hit, uart_hit;
    logic        fifo_empty, fifo_full, pop, push_ok, div_last;

    // The CPU shifts store data out LSB-last, so the bus word arrives bit-reversed.
    always_comb begin
        wdata = '0;
        for (int i = 0; i < 32; i++) begin
            wdata[i] = cpu_data[31-i];
        end
    end

    // Offsets compare only addr[7:2]; addr[23:8] and addr[1:0] alias across the page.
    always_comb begin
        do_write = cpu_store_data & addr_pending_q;
        page_hit = (addr_q[31:24] == PERIPH_PAGE);
        gpio_hit = do_write & page_hit & (addr_q[7:2] == GPIO_OFFSET[7:2]);
        uart_hit = do_write & page_hit & (addr_q[7:2] == UART_OFFSET[7:2]);
    end

    always_comb begin
        addr_d         = addr_q;
        addr_pending_d = addr_pending_q;
        gpio_d         = gpio_q;
        if (do_write) begin
            addr_pending_d = 1'b0;
        end
        if (cpu_store_addr) begin
            addr_d         = cpu_data;
            addr_pending_d = 1'b1;
        end
        if (gpio_hit) begin
            gpio_d = wdata[GPIO_WIDTH-1:0];
        end
    end

    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        div_last   = (div_q == DIV_W'(CLKS_PER_BIT - 1));
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q[PTR_W-1:0]];
                    div_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (div_last) begin
                    div_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DATA: begin
                if (div_last) begin
                    div_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_STOP: begin
                if (div_last) begin
                    div_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q[PTR_W-1:0]];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        mem_d      = mem_q;
        push_ok    = uart_hit & (~fifo_full | pop);
        overflow_d = overflow_q | (uart_hit & fifo_full & ~pop);
        if (push_ok) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = wdata[7:0];
        end
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
    end

    // Line level and busy are derived from next-state values so both are registered.
    always_comb begin
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (wr_ptr_d != rd_ptr_d) | (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q         <= '0;
            addr_pending_q <= 1'b0;
            gpio_q         <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            overflow_q     <= 1'b0;
            state_q        <= S_IDLE;
            div_q          <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            tx_q           <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            addr_q         <= addr_d;
            addr_pending_q <= addr_pending_d;
            gpio_q         <= gpio_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            overflow_q     <= overflow_d;
            state_q        <= state_d;
            div_q          <= div_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            tx_q           <= tx_d;
            busy_q         <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign gpio_out      = gpio_q;
    assign uart_tx       = tx_q;
    assign uart_busy     = busy_q;
    assign uart_overflow = overflow_q;
endmodule

// File: tb/tb_nanov_store_periph.sv
// Directed bench for nanov_store_periph: GPIO writes, decode/aliasing, UART framing,
// FIFO overflow, reset mid-frame and address-replacement behaviour.
module tb_nanov_store_periph;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_data;
  logic        cpu_store_addr;
  logic        cpu_store_data;
  logic [7:0]  gpio_out;
  logic        uart_tx;
  logic        uart_busy;
  logic        uart_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nanov_store_periph dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_data       (cpu_data),
    .cpu_store_addr (cpu_store_addr),
    .cpu_store_data (cpu_store_data),
    .gpio_out       (gpio_out),
    .uart_tx        (uart_tx),
    .uart_busy      (uart_busy),
    .uart_overflow  (uart_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns just after the posedge that samples the data strobe.
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    cpu_store_addr = 1'b1;
    cpu_data       = addr;
    @(negedge clk);
    cpu_store_addr = 1'b0;
    cpu_store_data = 1'b1;
    cpu_data       = bitrev(data);
    @(negedge clk);
    cpu_store_data = 1'b0;
    cpu_data       = '0;
  endtask

  task automatic wait_start(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (uart_tx !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(k < 400), 32'd1);
  endtask

  // Entered at the first negedge where the start bit is on the line; samples mid-bit.
  task automatic check_frame(input string tag, input logic [7:0] b);
    tick(8);
    chk($sformatf("%s_start", tag), uart_tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(16);
      chk($sformatf("%s_bit%0d", tag, i), uart_tx, b[i]);
    end
    tick(16);
    chk($sformatf("%s_stop", tag), uart_tx, 1'b1);
    chk($sformatf("%s_busy_stop", tag), uart_busy, 1'b1);
    tick(8);
  endtask

  initial begin
    rst            = 1'b1;
    cpu_data       = '0;
    cpu_store_addr = 1'b0;
    cpu_store_data = 1'b0;
    tick(3);
    rst = 1'b0;
    chk("rst_gpio", gpio_out, 8'h00);
    chk("rst_tx", uart_tx, 1'b1);
    chk("rst_busy", uart_busy, 1'b0);
    chk("rst_ovf", uart_overflow, 1'b0);

    // GPIO write, aliasing, and simultaneous strobes
    store(32'h1000_0000, 32'h0000_00A5);
    chk("gpio_a5", gpio_out, 8'hA5);
    chk("gpio_tx_idle", uart_tx, 1'b1);
    chk("gpio_busy_idle", uart_busy, 1'b0);
    store(32'h10AB_CD03, 32'h0000_005A);
    chk("gpio_alias", gpio_out, 8'h5A);
    @(negedge clk);
    cpu_store_addr = 1'b1;
    cpu_data       = 32'h1000_0000;
    @(negedge clk);
    cpu_store_data = 1'b1;
    @(negedge clk);
    cpu_store_addr = 1'b0;
    cpu_store_data = 1'b0;
    chk("both_strobe_old_addr", gpio_out, 8'h08);
    @(negedge clk);
    cpu_store_data = 1'b1;
    cpu_data       = bitrev(32'h77);
    @(negedge clk);
    cpu_store_data = 1'b0;
    chk("both_strobe_new_addr", gpio_out, 8'h77);

    // Off-page stores and orphan data strobe
    store(32'h0000_1000, 32'h11);
    chk("off_low_gpio", gpio_out, 8'h77);
    store(32'h2000_0000, 32'h22);
    chk("off_high_gpio", gpio_out, 8'h77);
    store(32'h2000_0004, 32'h33);
    tick(3);
    chk("off_uart_tx", uart_tx, 1'b1);
    chk("off_uart_busy", uart_busy, 1'b0);
    store(32'h1000_0000, 32'h3C);
    chk("gpio_3c", gpio_out, 8'h3C);
    @(negedge clk);
    cpu_store_data = 1'b1;
    cpu_data       = bitrev(32'hFF);
    @(negedge clk);
    cpu_store_data = 1'b0;
    chk("orphan_data", gpio_out, 8'h3C);

    // Single UART frame with exact start latency
    store(32'h1000_0004, 32'h55);
    chk("u55_tx_pre", uart_tx, 1'b1);
    chk("u55_busy_push", uart_busy, 1'b1);
    tick(1);
    chk("u55_start_lat", uart_tx, 1'b0);
    check_frame("u55", 8'h55);
    chk("u55_busy_done", uart_busy, 1'b0);
    chk("u55_tx_done", uart_tx, 1'b1);
    chk("u55_gpio", gpio_out, 8'h3C);

    // Back-to-back frames and FIFO overflow
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          store(32'h1000_0004, 32'(k));
          tick(25);
        end
      end
      begin
        wait_start("b2b_first_start");
        for (int f = 1; f <= 5; f++) begin
          check_frame($sformatf("b2b%0d", f), 8'(f));
          if (f < 5) chk($sformatf("b2b%0d_nogap", f), uart_tx, 1'b0);
        end
      end
    join
    chk("b2b_end_tx", uart_tx, 1'b1);
    chk("b2b_end_busy", uart_busy, 1'b0);
    chk("b2b_overflow", uart_overflow, 1'b1);

    // Second address replaces the first
    @(negedge clk);
    cpu_store_addr = 1'b1;
    cpu_data       = 32'h1000_0000;
    @(negedge clk);
    cpu_data       = 32'h1000_0004;
    @(negedge clk);
    cpu_store_addr = 1'b0;
    cpu_store_data = 1'b1;
    cpu_data       = bitrev(32'h41);
    @(negedge clk);
    cpu_store_data = 1'b0;
    cpu_data       = '0;
    chk("readdr_gpio", gpio_out, 8'h3C);
    chk("readdr_busy", uart_busy, 1'b1);
    tick(1);
    chk("readdr_start", uart_tx, 1'b0);
    check_frame("u41", 8'h41);
    chk("u41_busy_done", uart_busy, 1'b0);

    // Reset in the middle of data bit 3 with a byte still queued
    store(32'h1000_0000, 32'h9C);
    chk("pre_rst_gpio", gpio_out, 8'h9C);
    store(32'h1000_0004, 32'h55);
    store(32'h1000_0004, 32'h33);
    tick(70);
    chk("pre_rst_bit3", uart_tx, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_tx", uart_tx, 1'b1);
    chk("mid_rst_busy", uart_busy, 1'b0);
    chk("mid_rst_gpio", gpio_out, 8'h00);
    chk("mid_rst_ovf", uart_overflow, 1'b0);
    tick(20);
    chk("post_rst_tx_idle", uart_tx, 1'b1);
    chk("post_rst_fifo_empty", uart_busy, 1'b0);
    store(32'h1000_0004, 32'hC3);
    tick(1);
    chk("post_rst_start", uart_tx, 1'b0);
    check_frame("uc3", 8'hC3);
    chk("uc3_busy_done", uart_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
